alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Command-issuing front end for the tiny 4-bit ALU. Accepts packed ALU commands over a valid/ready stream into a small FIFO and drives the ALU's `ui_in`, `uio` and `ena` pins one command at a time. It waits out the ALU's two-register pipeline, samples its `uo_out` word, and returns the result with an opcode echo on a valid/ready response stream. It sits between a host or test controller and the ALU instance, on the same clock.

## Interface
Parameters
- DEPTH, 8: command FIFO entries; power of 2, at least 2.
- ALU_LAT, 2: ALU input-to-`uo_out` register stages.

Ports. One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ena  in  1  issue enable; when low, no new command is popped
- flush  in  1  sync clear of FIFO and in-flight command
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_data  in  12  {opcode[3:0], B[3:0], A[3:0]}
- rsp_valid  out  1  response held
- rsp_ready  in  1  response accepted
- rsp_data  out  12  {opcode[3:0], uo[7:0]}; uo = {Z,S,V,C,result[3:0]}
- alu_ui  out  8  {B,A} to ALU `ui_in`
- alu_uio  out  8  {4'b0, opcode} to ALU `uio`
- alu_ena  out  1  to ALU `ena`
- alu_uo  in  8  from ALU `uo_out`
- busy  out  1  state not IDLE
- fifo_count  out  $clog2(DEPTH)+1  entries held

## Operation
- FIFO
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count != DEPTH); there is no pass-through when full.
  - Read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if ena && FIFO not empty, pop the head, register alu_ui/alu_uio from it, set alu_ena=1, load cnt=ALU_LAT, go to WAIT.
  - WAIT: if cnt==0, capture {opcode, alu_uo} into rsp_data, set rsp_valid=1, go to RESP. Otherwise decrement cnt.
  - RESP: on rsp_ready, clear rsp_valid and alu_ena, go to IDLE.
- alu_ui and alu_uio hold their values from the issue edge until the next issue. alu_ena stays high from issue through capture.
- Every opcode returns a response, including REG_WRITE (result 0, Z=1) and undefined opcodes 1100–1111 (ALU returns 0).
- The sequencer does not interpret flags; alu_uo is passed through unchanged.
- flush takes priority over all other actions: empty the FIFO, clear rsp_valid, clear alu_ena, go to IDLE. A cmd push in the same cycle is dropped.
- Dropping ena mid-command does not abort it; it only blocks the next pop.

## Timing
- Reset values:
  - alu_ui=0, alu_uio=0, alu_ena=0
  - rsp_valid=0, rsp_data=0
  - cmd_ready=1, busy=0, fifo_count=0
- Issue edge T0 (pop). Cycle-by-cycle with ALU_LAT=2:
  - ALU registers result at T1.
  - `uo_out` updates at T2.
  - Capture at T3; rsp_valid is high after T3.
  - Issue to rsp_valid is ALU_LAT+1 edges.
- Back-to-back throughput is one command per ALU_LAT+3 cycles when rsp_ready is held high.
- rsp_data is stable while rsp_valid && !rsp_ready.
- A command pushed into an empty FIFO while IDLE is popped at the next edge, not the same one.
- Reset mid-operation returns all outputs to reset values immediately and asynchronously.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, PASS_B=7, REG_WRITE=8, REG_READ=9, ADD_REG=10, SUB_REG=11
  - `uo` bit indices: Z=7, S=6, V=5, C=4, RES=3:0
  - ALU_LAT default
  - cmd/rsp field widths
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO with count and sync flush. The FSM lives in the top.

## Test plan
- ADD, cmd_data=0x097 (A=7, B=9), rsp_ready=1 → rsp_data=0x090 (C=1, Z=1); rsp_valid high exactly 3 edges after pop.
- SUB, cmd_data=0x135 (A=5, B=3) → rsp_data=0x102. ADD 7+1 (0x017) → rsp_data=0x068 (S=1, V=1).
- REG_WRITE 0x83A (A=0xA, addr 3) → rsp 0x880. Then REG_READ 0x930 → rsp 0x94A.
- With rsp_ready=0, push until cmd_ready drops → exactly DEPTH+1 pushes accepted (one in flight, DEPTH in FIFO). Then release rsp_ready → responses return in push order, with rsp_data stable while stalled.
- flush asserted in WAIT → rsp_valid stays 0, fifo_count=0, alu_ena=0. The next pushed ADD 0x011 returns 0x002.
- rst_n low mid-WAIT → all outputs return to reset values in the same cycle. After release, a fresh command completes normally. ena=0 with a non-empty FIFO → no pop, busy=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, uo_out bit map, latency default and stream field types for the ALU command sequencer
package alu_pkg;
    localparam int ALU_LAT_DEF = 2;
    localparam int OP_W        = 4;
    localparam int OPND_W      = 4;
    localparam int UO_W        = 8;
    localparam int CMD_W       = OP_W + 2 * OPND_W;
    localparam int RSP_W       = OP_W + UO_W;

    localparam logic [3:0] OP_ADD       = 4'd0;
    localparam logic [3:0] OP_SUB       = 4'd1;
    localparam logic [3:0] OP_AND       = 4'd2;
    localparam logic [3:0] OP_OR        = 4'd3;
    localparam logic [3:0] OP_XOR       = 4'd4;
    localparam logic [3:0] OP_SHL       = 4'd5;
    localparam logic [3:0] OP_SHR       = 4'd6;
    localparam logic [3:0] OP_PASS_B    = 4'd7;
    localparam logic [3:0] OP_REG_WRITE = 4'd8;
    localparam logic [3:0] OP_REG_READ  = 4'd9;
    localparam logic [3:0] OP_ADD_REG   = 4'd10;
    localparam logic [3:0] OP_SUB_REG   = 4'd11;

    localparam int UO_Z      = 7;
    localparam int UO_S      = 6;
    localparam int UO_V      = 5;
    localparam int UO_C      = 4;
    localparam int UO_RES_HI = 3;
    localparam int UO_RES_LO = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] a;
    } cmd_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [UO_W-1:0] uo;
    } rsp_t;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and response valid/ready streams between host and sequencer
//   cmd_valid/cmd_ready/cmd_data : host -> sequencer, {opcode, B, A}
//   rsp_valid/rsp_ready/rsp_data : sequencer -> host, {opcode, uo}
//   master = host side, slave = sequencer side
interface alu_cmd_sequencer_if;
    import alu_pkg::*;
    logic cmd_valid;
    logic cmd_ready;
    cmd_t cmd_data;
    logic rsp_valid;
    logic rsp_ready;
    rsp_t rsp_data;
    modport master (output cmd_valid, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data);
    modport slave (input cmd_valid, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with occupancy count and synchronous flush
//   push/din, pop/dout : write and read sides, dout shows the head entry
//   flush              : empties the FIFO and drops a same-cycle push
//   count/full/empty   : occupancy status
module alu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time and returns {opcode, uo_out}
//   clk, rst_n         : clock, asynchronous active-low reset
//   ena                : allows popping the next command
//   flush              : clears FIFO and any in-flight command
//   bus                : command/response streams (slave side)
//   alu_ui/uio/ena     : drive the ALU inputs; alu_uo samples its uo_out
//   busy, fifo_count   : status
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   flush,
    alu_cmd_sequencer_if.slave     bus,
    output logic [7:0]             alu_ui,
    output logic [7:0]             alu_uio,
    output logic                   alu_ena,
    input  logic [7:0]             alu_uo,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int CW = $clog2(ALU_LAT + 2);
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;
    logic          pop;
    cmd_t          head;
    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (bus.cmd_valid),
        .pop   (pop),
        .din   (bus.cmd_data),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
    assign bus.cmd_ready = !full;
    assign busy          = state != IDLE;
    assign pop           = state == IDLE && ena && !empty && !flush;
    // cnt counts the ALU pipeline down; capture happens on the edge after it reaches zero,
    // giving ALU_LAT+1 edges from issue to rsp_valid.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            alu_ui        <= '0;
            alu_uio       <= '0;
            alu_ena       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else if (flush) begin
            state         <= IDLE;
            alu_ena       <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (pop) begin
                        alu_ui  <= {head.b, head.a};
                        alu_uio <= {4'b0, head.op};
                        alu_ena <= 1'b1;
                        cnt     <= CW'(ALU_LAT);
                        state   <= WAIT;
                    end
                WAIT:
                    if (cnt == '0) begin
                        bus.rsp_data  <= {alu_uio[3:0], alu_uo};
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                RESP:
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        alu_ena       <= 1'b0;
                        state         <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule
